// File: rtl/operand_fetch_pkg.sv
// Shared operand-source encoding used by the decoder and the operand fetch unit.
package operand_fetch_pkg;

    typedef enum logic [2:0] {
        SRC_REG       = 3'd0,
        SRC_IMMEDIATE = 3'd1,
        SRC_MEM_ADDR  = 3'd2,
        SRC_INDIRECT  = 3'd3
    } data_src_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Data-memory read port between the operand fetch unit (master) and the memory (slave).
interface operand_fetch_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [WIDTH-1:0]  mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/operand_fetch.sv
// Operand fetch unit: resolves direct and indirect memory operands for the ALU mux,
// with a bounded wait on each memory read.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  data_src_t            source,
    input  logic [ADDR_W-1:0]    operand,
    operand_fetch_if.master      mem,
    output logic [WIDTH-1:0]     mem_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_PTR  = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              use_ptr_q;
    logic [WIDTH-1:0]  mem_data_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              timeout_hit;

    // Pointer read data becomes an address: zero-extend or keep the low bits.
    function automatic logic [ADDR_W-1:0] to_addr(input logic [WIDTH-1:0] d);
        return ADDR_W'(d);
    endfunction

    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST) && !mem.mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            ptr_q      <= '0;
            use_ptr_q  <= 1'b0;
            mem_data_q <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    err_q <= 1'b0;
                    if (start) begin
                        addr_q    <= operand;
                        use_ptr_q <= 1'b0;
                        cnt_q     <= '0;
                        case (source)
                            SRC_MEM_ADDR: state_q <= RD_DATA;
                            SRC_INDIRECT: state_q <= RD_PTR;
                            default:      state_q <= DONE;
                        endcase
                    end
                end
                RD_PTR: begin
                    if (mem.mem_ack) begin
                        ptr_q     <= to_addr(mem.mem_rdata);
                        use_ptr_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= RD_DATA;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RD_DATA: begin
                    // An ack in the last allowed cycle takes priority over the timeout.
                    if (mem.mem_ack) begin
                        mem_data_q <= mem.mem_rdata;
                        state_q    <= DONE;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs are pure register / state decode; nothing passes straight from an input.
    assign mem.mem_req  = (state_q == RD_PTR) || (state_q == RD_DATA);
    assign mem.mem_addr = use_ptr_q ? ptr_q : addr_q;
    assign mem_data     = mem_data_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign err          = err_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a per-fetch timeline model drives the memory side
// and supplies the expected outputs that one negedge process compares every cycle.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 8;
    localparam int TO     = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    data_src_t        source = SRC_REG;
    logic [ADDR_W-1:0] operand = '0;
    logic [WIDTH-1:0] mem_data;
    logic             busy, done, err;

    operand_fetch_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) mem ();

    operand_fetch #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .source   (source),
        .operand  (operand),
        .mem      (mem),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    bit          chk_en = 1'b0;
    logic        exp_busy, exp_done, exp_err, exp_req;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_data;
    int          cur_c, done_cyc, req_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("err", err, exp_err);
            check("mem_req", mem.mem_req, exp_req);
            check("mem_data", mem_data, exp_data);
            if (exp_req) check("mem_addr", mem.mem_addr, exp_addr);
            if (done) done_cyc = cur_c;
            if (mem.mem_req) req_cnt++;
        end
    end

    task automatic set_idle_exp();
        exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_req = 1'b0; exp_addr = '0;
    endtask

    task automatic idle(input int n, input bit spur);
        repeat (n) begin
            @(posedge clk); #1;
            start = 1'b0;
            mem.mem_ack = spur;
            mem.mem_rdata = 8'hFF;
            set_idle_exp();
        end
    endtask

    // d = ack delay in cycles for that read; negative means the ack never comes.
    task automatic fetch(input data_src_t src, input logic [7:0] opnd,
                         input logic [7:0] rd0, input int d0,
                         input logic [7:0] rd1, input int d1, input bit ign);
        logic       r_req[16];
        logic [7:0] r_addr[16];
        logic       r_ack[16];
        logic [7:0] r_rdata[16];
        logic [7:0] ra[2];
        logic [7:0] rv[2];
        int         rd[2];
        int         n_reads, c, dc, n;
        bit         to;
        logic [7:0] new_data;
        for (int i = 0; i < 16; i++) begin
            r_req[i] = 1'b0; r_addr[i] = '0; r_ack[i] = 1'b0; r_rdata[i] = 8'h00;
        end
        n_reads = (src == SRC_MEM_ADDR) ? 1 : (src == SRC_INDIRECT) ? 2 : 0;
        ra[0] = opnd; rv[0] = rd0; rd[0] = d0;
        ra[1] = rd0;  rv[1] = rd1; rd[1] = d1;
        c = 1; to = 1'b0;
        for (int r = 0; r < n_reads && !to; r++) begin
            to = (rd[r] < 0) || (rd[r] >= TO);
            n  = to ? TO : rd[r] + 1;
            for (int k = 0; k < n; k++) begin
                r_req[c]   = 1'b1;
                r_addr[c]  = ra[r];
                r_ack[c]   = !to && (k == rd[r]);
                r_rdata[c] = r_ack[c] ? rv[r] : ~rv[r];
                c++;
            end
        end
        dc = c;
        new_data = (!to && n_reads > 0) ? rv[n_reads-1] : exp_data;

        @(posedge clk); #1;
        start = 1'b1; source = src; operand = opnd;
        mem.mem_ack = 1'b0; mem.mem_rdata = 8'h00;
        cur_c = 0; done_cyc = -1; req_cnt = 0;
        set_idle_exp();
        for (int i = 1; i <= dc; i++) begin
            @(posedge clk); #1;
            cur_c = i;
            start = ign && (i == 1 || i == dc);
            source = SRC_IMMEDIATE;
            operand = 8'hFF;
            mem.mem_ack = r_ack[i];
            mem.mem_rdata = r_rdata[i];
            exp_busy = 1'b1;
            exp_req  = r_req[i];
            exp_addr = r_addr[i];
            exp_done = (i == dc);
            exp_err  = (i == dc) && to;
            if (i == dc) exp_data = new_data;
        end
    endtask

    task automatic pin(input string nm, input int lat, input int reqs, input logic [7:0] data);
        @(negedge clk); #1;
        check({nm, "_latency"}, done_cyc, lat);
        check({nm, "_req_cycles"}, req_cnt, reqs);
        check({nm, "_data"}, mem_data, data);
    endtask

    initial begin
        mem.mem_ack = 1'b0;
        mem.mem_rdata = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_req", mem.mem_req, 0);
        check("rst_addr", mem.mem_addr, 0);
        check("rst_data", mem_data, 0);
        #19 rst_n = 1'b1;
        exp_data = 8'h00;
        set_idle_exp();
        chk_en = 1'b1;
        idle(2, 1'b0);

        fetch(SRC_MEM_ADDR, 8'h3C, 8'hA5, 0, 8'h00, 0, 1'b0);
        pin("direct", 2, 1, 8'hA5);

        // Reset while a direct read is outstanding.
        @(posedge clk); #1;
        start = 1'b1; source = SRC_MEM_ADDR; operand = 8'h55; mem.mem_ack = 1'b0;
        set_idle_exp();
        @(posedge clk); #1;
        start = 1'b0;
        exp_busy = 1'b1; exp_req = 1'b1; exp_addr = 8'h55;
        #2 chk_en = 1'b0;
        check("pre_rst_req", mem.mem_req, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", mem.mem_req, 0);
        check("mid_rst_addr", mem.mem_addr, 0);
        check("mid_rst_data", mem_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        exp_data = 8'h00;
        set_idle_exp();
        chk_en = 1'b1;
        idle(3, 1'b0);

        fetch(SRC_INDIRECT, 8'h10, 8'h42, 2, 8'h7E, 1, 1'b0);
        pin("indirect", 6, 5, 8'h7E);
        fetch(SRC_IMMEDIATE, 8'h11, 8'h00, 0, 8'h00, 0, 1'b0);
        pin("imm", 1, 0, 8'h7E);
        fetch(SRC_REG, 8'h12, 8'h00, 0, 8'h00, 0, 1'b0);
        pin("reg", 1, 0, 8'h7E);
        fetch(data_src_t'(3'd6), 8'h13, 8'h00, 0, 8'h00, 0, 1'b0);
        pin("other_src", 1, 0, 8'h7E);
        fetch(SRC_INDIRECT, 8'h80, 8'hC3, 0, 8'h5A, 0, 1'b0);
        pin("indirect_fast", 3, 2, 8'h5A);

        fetch(SRC_MEM_ADDR, 8'h20, 8'h99, -1, 8'h00, 0, 1'b0);
        pin("timeout", 5, 4, 8'h5A);
        fetch(SRC_MEM_ADDR, 8'h21, 8'h3D, 3, 8'h00, 0, 1'b0);
        pin("last_cycle_ack", 5, 4, 8'h3D);
        fetch(SRC_INDIRECT, 8'h30, 8'h44, 0, 8'h00, -1, 1'b0);
        pin("timeout_data", 6, 5, 8'h3D);

        idle(3, 1'b1);
        fetch(SRC_MEM_ADDR, 8'h40, 8'hB7, 1, 8'h00, 0, 1'b1);
        fetch(SRC_MEM_ADDR, 8'h41, 8'h6C, 0, 8'h00, 0, 1'b0);
        pin("after_done", 2, 1, 8'h6C);
        idle(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
